// File: rtl/arb_mux_if.sv
// Handshake bundle between N competing sources and one sink of arb_mux.
// The slave modport is the arbiter's view; master is the traffic generator's view.
interface arb_mux_if #(
   parameter int WIDTH = 32,
   parameter int N     = 4
);
   localparam int SEL_W = $clog2(N);

   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SEL_W-1:0]   out_sel;
   logic               out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/arb_mux.sv
// Registered N-way arbitrating multiplexer: one valid source per cycle, chosen by
// fixed or round-robin priority, is captured into a single output register stage.
module arb_mux #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter bit RR    = 1'b1
) (
   input logic      clk,
   input logic      resetn,
   arb_mux_if.slave bus
);
   localparam int SEL_W = $clog2(N);

   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] win_s;
   logic             found_s;
   logic             load_s;
   logic [WIDTH-1:0] win_data_s;
   logic [N-1:0]     ready_s;

   // Scanned from the far end so the last hit is the one nearest ptr.
   function automatic logic [SEL_W:0] pick_winner(input logic [N-1:0]     valid,
                                                  input logic [SEL_W-1:0] ptr);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] idx;
      res = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = SEL_W'((int'(ptr) + k) % N);
         if (valid[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign load_s = !valid_q | bus.out_ready;

   // Winner selection, payload mux and per-channel accept.
   always_comb begin
      {found_s, win_s} = pick_winner(bus.in_valid, ptr_q);
      win_data_s = '0;
      for (int k = 0; k < N; k++) begin
         if (win_s == SEL_W'(k)) begin
            win_data_s = bus.in_data[k*WIDTH +: WIDTH];
         end
      end
      ready_s = '0;
      if (resetn && load_s && found_s) begin
         ready_s[win_s] = 1'b1;
      end else begin
         ready_s = '0;
      end
   end

   // Next state of the output register and priority pointer.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      if (load_s) begin
         if (found_s) begin
            valid_d = 1'b1;
            data_d  = win_data_s;
            sel_d   = win_s;
            if (RR) begin
               if (win_s == SEL_W'(N - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = win_s + SEL_W'(1);
               end
            end else begin
               ptr_d = '0;
            end
         end else begin
            valid_d = 1'b0;
         end
      end else begin
         valid_d = valid_q;
      end
   end

   // State registers; a beat held at reset is dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.in_ready  = ready_s;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: a round-robin and a fixed-priority instance share one stimulus stream.
module tb_arb_mux;
   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  sel;
   } beat_t;

   typedef struct {
      logic [3:0] iv;
      logic       ordy;
      int         g_rr;
      int         g_fp;
   } vec_t;

   logic         clk;
   logic         resetn;
   logic [3:0]   in_valid_t;
   logic [127:0] in_data_t;
   logic         out_ready_t;

   logic [3:0]   act_rdy   [2];
   logic         act_valid [2];
   logic [31:0]  act_data  [2];
   logic [1:0]   act_sel   [2];

   int           checks;
   int           errors;
   logic         exp_valid [2];
   beat_t        held      [2];
   beat_t        sb_rr[$];
   beat_t        sb_fp[$];
   vec_t         vecs      [23];

   arb_mux_if #(.WIDTH(32), .N(4)) if_rr ();
   arb_mux_if #(.WIDTH(32), .N(4)) if_fp ();

   arb_mux #(.WIDTH(32), .N(4), .RR(1'b1)) dut_rr (.clk(clk), .resetn(resetn), .bus(if_rr.slave));
   arb_mux #(.WIDTH(32), .N(4), .RR(1'b0)) dut_fp (.clk(clk), .resetn(resetn), .bus(if_fp.slave));

   assign if_rr.in_valid  = in_valid_t;
   assign if_rr.in_data   = in_data_t;
   assign if_rr.out_ready = out_ready_t;
   assign if_fp.in_valid  = in_valid_t;
   assign if_fp.in_data   = in_data_t;
   assign if_fp.out_ready = out_ready_t;

   assign act_rdy[0]   = if_rr.in_ready;
   assign act_valid[0] = if_rr.out_valid;
   assign act_data[0]  = if_rr.out_data;
   assign act_sel[0]   = if_rr.out_sel;
   assign act_rdy[1]   = if_fp.in_ready;
   assign act_valid[1] = if_fp.out_valid;
   assign act_data[1]  = if_fp.out_data;
   assign act_sel[1]   = if_fp.out_sel;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] onehot(input int g);
      logic [3:0] r;
      r = 4'b0000;
      if (g >= 0) r[g[1:0]] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a falling edge; g_* is the expected winner or -1.
   task automatic do_cycle(input string tag_name, input logic [3:0] iv, input logic ordy,
                           input int g_rr, input int g_fp, input logic [15:0] tag);
      int    g  [2];
      logic  nv [2];
      beat_t b;
      g[0] = g_rr;
      g[1] = g_fp;
      in_valid_t  = iv;
      out_ready_t = ordy;
      for (int i = 0; i < 4; i++) in_data_t[i*32 +: 32] = {tag, 16'h00A0 + 16'(i)};
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s in_ready dut%0d", tag_name, d), 32'(act_rdy[d]), 32'(onehot(g[d])));
         if (g[d] >= 0) begin
            b.data = {tag, 16'h00A0 + 16'(g[d])};
            b.sel  = g[d][1:0];
            if (d == 0) sb_rr.push_back(b);
            else        sb_fp.push_back(b);
            nv[d] = 1'b1;
         end else begin
            nv[d] = exp_valid[d] && !ordy;
         end
      end
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         exp_valid[d] = nv[d];
         chk($sformatf("%s out_valid dut%0d", tag_name, d), 32'(act_valid[d]), 32'(exp_valid[d]));
         if (g[d] >= 0) begin
            if (d == 0 && sb_rr.size() > 0)      held[d] = sb_rr.pop_front();
            else if (d == 1 && sb_fp.size() > 0) held[d] = sb_fp.pop_front();
         end
         chk($sformatf("%s out_data dut%0d", tag_name, d), act_data[d], held[d].data);
         chk($sformatf("%s out_sel dut%0d", tag_name, d), 32'(act_sel[d]), 32'(held[d].sel));
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      resetn      = 1'b0;
      in_valid_t  = 4'b0000;
      in_data_t   = '0;
      out_ready_t = 1'b0;
      for (int d = 0; d < 2; d++) begin
         exp_valid[d] = 1'b0;
         held[d]      = '0;
      end

      vecs[0]  = '{4'b1010, 1'b1,  1,  1};
      vecs[1]  = '{4'b1111, 1'b1,  2,  0};
      vecs[2]  = '{4'b1111, 1'b1,  3,  0};
      vecs[3]  = '{4'b1111, 1'b1,  0,  0};
      vecs[4]  = '{4'b1111, 1'b1,  1,  0};
      vecs[5]  = '{4'b1111, 1'b1,  2,  0};
      vecs[6]  = '{4'b1111, 1'b1,  3,  0};
      vecs[7]  = '{4'b1111, 1'b1,  0,  0};
      vecs[8]  = '{4'b0001, 1'b1,  0,  0};
      vecs[9]  = '{4'b0000, 1'b1, -1, -1};
      vecs[10] = '{4'b0000, 1'b0, -1, -1};
      vecs[11] = '{4'b1010, 1'b0,  1,  1};
      vecs[12] = '{4'b1111, 1'b0, -1, -1};
      vecs[13] = '{4'b1111, 1'b0, -1, -1};
      vecs[14] = '{4'b1111, 1'b0, -1, -1};
      vecs[15] = '{4'b1111, 1'b1,  2,  0};
      vecs[16] = '{4'b1000, 1'b1,  3,  3};
      vecs[17] = '{4'b1010, 1'b1,  1,  1};
      vecs[18] = '{4'b1010, 1'b1,  3,  1};
      vecs[19] = '{4'b1010, 1'b1,  1,  1};
      vecs[20] = '{4'b0100, 1'b0, -1, -1};
      vecs[21] = '{4'b0100, 1'b1,  2,  2};
      vecs[22] = '{4'b0000, 1'b1, -1, -1};

      repeat (3) @(negedge clk);
      in_valid_t = 4'b1111;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset out_valid dut%0d", d), 32'(act_valid[d]), 32'd0);
         chk($sformatf("reset out_data dut%0d", d), act_data[d], 32'd0);
         chk($sformatf("reset in_ready dut%0d", d), 32'(act_rdy[d]), 32'd0);
      end
      @(negedge clk);
      resetn = 1'b1;

      for (int r = 0; r < 23; r++) begin
         do_cycle($sformatf("vec%0d", r), vecs[r].iv, vecs[r].ordy,
                  vecs[r].g_rr, vecs[r].g_fp, 16'(r + 1));
      end

      // Reset while a beat from channel 2 is stalled in the register.
      do_cycle("rst_load", 4'b0100, 1'b0, 2, 2, 16'h00F0);
      do_cycle("rst_stall", 4'b1111, 1'b0, -1, -1, 16'h00F1);
      #2;
      resetn = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("midreset out_valid dut%0d", d), 32'(act_valid[d]), 32'd0);
         chk($sformatf("midreset out_sel dut%0d", d), 32'(act_sel[d]), 32'd0);
         chk($sformatf("midreset out_data dut%0d", d), act_data[d], 32'd0);
         chk($sformatf("midreset in_ready dut%0d", d), 32'(act_rdy[d]), 32'd0);
         exp_valid[d] = 1'b0;
         held[d]      = '0;
      end
      sb_rr.delete();
      sb_fp.delete();
      @(negedge clk);
      resetn = 1'b1;
      do_cycle("post_rst", 4'b1010, 1'b1, 1, 1, 16'h00F2);
      do_cycle("post_idle", 4'b0000, 1'b1, -1, -1, 16'h00F3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
